// File: rtl/fios_seq_pkg.sv
// ============================================================================
// Module      : fios_seq_pkg
// Description : Shared types and helpers for the FIOS Montgomery multiplier
//               job sequencer: FSM state encoding, operand buffer select
//               codes and the padded A-window length function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fios_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHAIN = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_P = 2'd2;

  // A operand length rounded up to a whole number of PE_NB-word windows.
  function automatic int unsigned a_words(input int unsigned s, input int unsigned pe_nb);
    return ((s + pe_nb - 1) / pe_nb) * pe_nb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fios_word_buf.sv
// ============================================================================
// Module      : fios_word_buf
// Description : s-word operand register file with a wrapping write pointer,
//               a wrapping fetch (read) pointer and a whole-array parallel
//               load port used to feed results back as the next operand.
// Ports       : clock_i/reset_i     clock, synchronous active-high reset
//               wr_en_i/wr_data_i   word write at the write pointer
//               wr_clr_i            clear the write pointer
//               rd_adv_i/rd_clr_i   advance / clear the fetch pointer
//               ld_en_i/ld_data_i   parallel load of all s words
//               rd_data_o           word at the fetch pointer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fios_word_buf #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned s          = 8
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    wr_en_i,
  input  logic                    wr_clr_i,
  input  logic [WORD_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_adv_i,
  input  logic                    rd_clr_i,
  input  logic                    ld_en_i,
  input  logic [s*WORD_WIDTH-1:0] ld_data_i,
  output logic [WORD_WIDTH-1:0]   rd_data_o
);

  localparam int unsigned      PTR_W = (s > 1) ? $clog2(s) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(s - 1);

  logic [WORD_WIDTH-1:0] mem_q [s];
  logic [WORD_WIDTH-1:0] mem_d [s];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ld_en_i) begin
      for (int i = 0; i < int'(s); i++) begin
        mem_d[i] = ld_data_i[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end else if (wr_en_i) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (wr_clr_i) begin
      wr_ptr_d = '0;
    end
    if (rd_clr_i) begin
      rd_ptr_d = '0;
    end else if (rd_adv_i) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/fios_mm_sequencer.sv
// ============================================================================
// Module      : fios_mm_sequencer
// Description : Job-level front end for the FIOS Montgomery multiplier.
//               Buffers A/B/P operands, starts the core, services its
//               shift/fetch strobes, captures result words, optionally
//               chains results back as B, and drains results valid/ready.
// Ports       : ld_*   operand word load (sel 0=A 1=B 2=P 3=discard)
//               cmd_*  job start with chained-iteration count
//               res_*  result drain, least significant word first
//               core_* core interface (start, A window, B/P words, strobes)
//               busy_o not IDLE;  err_o sticky result-count/timeout error
// Options     : `define FIOS_MM_SEQUENCER_TIMEOUT_EN enables a RUN watchdog
//               of TIMEOUT_CYCLES cycles (START cycle included).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fios_mm_sequencer
  import fios_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 17,
  parameter int unsigned s              = 8,
  parameter int unsigned PE_NB          = 8,
  parameter int unsigned ITER_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        ld_valid_i,
  output logic                        ld_ready_o,
  input  logic [1:0]                  ld_sel_i,
  input  logic [WORD_WIDTH-1:0]       ld_data_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [ITER_W-1:0]           cmd_iter_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [WORD_WIDTH-1:0]       res_data_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic                        core_start_o,
  output logic [PE_NB*WORD_WIDTH-1:0] core_a_o,
  output logic [WORD_WIDTH-1:0]       core_b_o,
  output logic [WORD_WIDTH-1:0]       core_p_o,
  input  logic                        core_a_shift_i,
  input  logic                        core_b_fetch_i,
  input  logic                        core_p_fetch_i,
  input  logic                        core_res_push_i,
  input  logic                        core_done_i,
  input  logic [WORD_WIDTH-1:0]       core_res_i
);

  localparam int unsigned      A_WORDS  = a_words(s, PE_NB);
  localparam int unsigned      PTR_W    = (s > 1) ? $clog2(s) : 1;
  localparam int unsigned      CNT_W    = $clog2(s + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(s - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(s);

  state_e                        state_q, state_d;
  logic [ITER_W-1:0]             iter_q, iter_d;
  logic [PTR_W-1:0]              a_ptr_q, a_ptr_d;
  logic [A_WORDS*WORD_WIDTH-1:0] a_sh_q, a_sh_d;
  logic [CNT_W-1:0]              res_ptr_q, res_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic                          start_q, start_d;
  logic                          err_q, err_d;
  logic [WORD_WIDTH-1:0]         a_mem_q [s];
  logic [WORD_WIDTH-1:0]         a_mem_d [s];
  logic [WORD_WIDTH-1:0]         res_mem_q [s];
  logic [WORD_WIDTH-1:0]         res_mem_d [s];
  logic [A_WORDS*WORD_WIDTH-1:0] a_pad;
  logic [s*WORD_WIDTH-1:0]       res_flat;

`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  logic ld_fire, cmd_fire, in_run;

  assign ld_ready_o   = (state_q == ST_IDLE);
  // A load in the same cycle as a command takes priority.
  assign cmd_ready_o  = (state_q == ST_IDLE) && !ld_valid_i;
  assign ld_fire      = ld_valid_i && ld_ready_o;
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign in_run       = (state_q == ST_RUN);
  assign res_valid_o  = (state_q == ST_DRAIN);
  assign res_data_o   = res_mem_q[rd_ptr_q];
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;
  assign core_start_o = start_q;
  assign core_a_o     = a_sh_q[PE_NB*WORD_WIDTH-1:0];

  always_comb begin
    a_pad    = '0;
    res_flat = '0;
    for (int i = 0; i < int'(s); i++) begin
      a_pad[i*WORD_WIDTH +: WORD_WIDTH]    = a_mem_q[i];
      res_flat[i*WORD_WIDTH +: WORD_WIDTH] = res_mem_q[i];
    end
  end

  fios_word_buf #(.WORD_WIDTH(WORD_WIDTH), .s(s)) u_b_buf (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .wr_en_i   (ld_fire && (ld_sel_i == SEL_B)),
    .wr_clr_i  (cmd_fire),
    .wr_data_i (ld_data_i),
    .rd_adv_i  (in_run && core_b_fetch_i),
    .rd_clr_i  (state_q == ST_START),
    .ld_en_i   (state_q == ST_CHAIN),
    .ld_data_i (res_flat),
    .rd_data_o (core_b_o)
  );

  fios_word_buf #(.WORD_WIDTH(WORD_WIDTH), .s(s)) u_p_buf (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .wr_en_i   (ld_fire && (ld_sel_i == SEL_P)),
    .wr_clr_i  (cmd_fire),
    .wr_data_i (ld_data_i),
    .rd_adv_i  (in_run && core_p_fetch_i),
    .rd_clr_i  (state_q == ST_START),
    .ld_en_i   (1'b0),
    .ld_data_i ('0),
    .rd_data_o (core_p_o)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    a_ptr_d   = a_ptr_q;
    a_sh_d    = a_sh_q;
    res_ptr_d = res_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    a_mem_d   = a_mem_q;
    res_mem_d = res_mem_q;
`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_fire && (ld_sel_i == SEL_A)) begin
          a_mem_d[a_ptr_q] = ld_data_i;
          a_ptr_d          = (a_ptr_q == PTR_LAST) ? '0 : a_ptr_q + PTR_W'(1);
        end
        if (cmd_fire) begin
          iter_d  = (cmd_iter_i == '0) ? ITER_W'(1) : cmd_iter_i;
          a_ptr_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        a_sh_d    = a_pad;
        res_ptr_d = '0;
        rd_ptr_d  = '0;
`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
        wd_d      = WD_W'(1);
`endif
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (core_a_shift_i) begin
          a_sh_d = a_sh_q >> (PE_NB * WORD_WIDTH);
        end
        if (core_res_push_i) begin
          if (res_ptr_q != CNT_FULL) begin
            res_mem_d[res_ptr_q[PTR_W-1:0]] = core_res_i;
            res_ptr_d = res_ptr_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        // res_ptr_d already includes a push from this same cycle.
        if (core_done_i) begin
          if (res_ptr_d != CNT_FULL) begin
            err_d = 1'b1;
          end
          iter_d  = iter_q - ITER_W'(1);
          state_d = (iter_q > ITER_W'(1)) ? ST_CHAIN : ST_DRAIN;
        end
`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      ST_CHAIN: begin
        state_d = ST_START;
      end
      ST_DRAIN: begin
        if (res_ready_i) begin
          if (rd_ptr_q == PTR_LAST) begin
            rd_ptr_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_START);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      a_ptr_q   <= '0;
      a_sh_q    <= '0;
      res_ptr_q <= '0;
      rd_ptr_q  <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      a_ptr_q   <= a_ptr_d;
      a_sh_q    <= a_sh_d;
      res_ptr_q <= res_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      start_q   <= start_d;
      err_q     <= err_d;
`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    a_mem_q   <= a_mem_d;
    res_mem_q <= res_mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_fios_mm_sequencer.sv
// ============================================================================
// Module      : tb_fios_mm_sequencer
// Description : Self-checking bench for fios_mm_sequencer with a directed
//               behavioural core: single job, fetch wrap, chaining, result
//               count errors, backpressure, reset and watchdog behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fios_mm_sequencer;

  localparam int W  = 17;
  localparam int S  = 8;
  localparam int PE = 8;
`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_ready;
  logic [1:0]    ld_sel;
  logic [W-1:0]  ld_data;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_iter;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic          busy, err, core_start;
  logic [PE*W-1:0] core_a;
  logic [W-1:0]  core_b, core_p;
  logic          a_shift, b_fetch, p_fetch, res_push, done;
  logic [W-1:0]  core_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fios_mm_sequencer #(
    .WORD_WIDTH(W), .s(S), .PE_NB(PE), .ITER_W(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .ld_valid_i     (ld_valid),
    .ld_ready_o     (ld_ready),
    .ld_sel_i       (ld_sel),
    .ld_data_i      (ld_data),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_iter_i     (cmd_iter),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .busy_o         (busy),
    .err_o          (err),
    .core_start_o   (core_start),
    .core_a_o       (core_a),
    .core_b_o       (core_b),
    .core_p_o       (core_p),
    .core_a_shift_i (a_shift),
    .core_b_fetch_i (b_fetch),
    .core_p_fetch_i (p_fetch),
    .core_res_push_i(res_push),
    .core_done_i    (done),
    .core_res_i     (core_res)
  );

  typedef struct {
    logic         b_fetch;
    logic         p_fetch;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_p;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [PE*W-1:0] act, input logic [PE*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [W-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] it);
    cmd_valid = 1'b1;
    cmd_iter  = it;
    #1;
    check("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("start_pulse", core_start, 1);
    check("busy_start", busy, 1);
  endtask

  task automatic push_words(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      res_push = 1'b1;
      core_res = base + W'(i);
      tick();
    end
    res_push = 1'b0;
  endtask

  task automatic finish_job();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Drain S words, comparing the first n_chk against base+i.
  task automatic drain(input logic [W-1:0] base, input int n_chk);
    for (int i = 0; i < S; i++) begin
      check("drain_valid", res_valid, 1);
      if (i < n_chk) check("drain_data", res_data, base + W'(i));
      res_ready = 1'b1;
      tick();
    end
    res_ready = 1'b0;
    check("busy_after_drain", busy, 0);
    check("valid_after_drain", res_valid, 0);
  endtask

  initial begin
    logic [PE*W-1:0] exp_a;

    rst = 1'b1; ld_valid = 0; ld_sel = 0; ld_data = 0; cmd_valid = 0; cmd_iter = 0;
    res_ready = 0; a_shift = 0; b_fetch = 0; p_fetch = 0; res_push = 0; done = 0; core_res = 0;

    for (int i = 0; i < 16; i++) begin
      vecs[i].b_fetch = 1'b1;
      vecs[i].p_fetch = (i < 2);
      vecs[i].exp_b   = W'(9 + (i % 8));
      vecs[i].exp_p   = W'(17 + ((i < 2) ? i : 2));
    end

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_start", core_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();

    // Core strobes outside RUN are ignored
    res_push = 1'b1; done = 1'b1;
    tick();
    res_push = 1'b0; done = 1'b0;
    check("idle_strobe_err", err, 0);
    check("idle_strobe_busy", busy, 0);

    // Operand load; sel=3 words are discarded
    for (int i = 0; i < S; i++) load(2'd0, W'(1 + i));
    load(2'd3, W'(999));
    for (int i = 0; i < S; i++) load(2'd1, W'(9 + i));
    for (int i = 0; i < S; i++) load(2'd2, W'(17 + i));

    // Single job
    send_cmd(8'd1);
    tick();
    check("start_one_cycle", core_start, 0);
    for (int i = 0; i < PE; i++) exp_a[i*W +: W] = W'(1 + i);
    check("a_window", core_a, exp_a);
    for (int i = 0; i < 16; i++) begin
      check("b_word", core_b, vecs[i].exp_b);
      check("p_word", core_p, vecs[i].exp_p);
      b_fetch = vecs[i].b_fetch;
      p_fetch = vecs[i].p_fetch;
      tick();
    end
    b_fetch = 0; p_fetch = 0;
    a_shift = 1'b1;
    tick();
    a_shift = 1'b0;
    check("a_after_shift", core_a, 0);
    push_words(W'('h100), S);
    check("err_full_push", err, 0);
    finish_job();
    check("drain_entered", res_valid, 1);
    drain(W'('h100), S);
    check("err_single", err, 0);

    // Chained job: three iterations, RES fed back as B
    send_cmd(8'd3);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        check("chain_no_start", core_start, 0);
        check("chain_no_valid", res_valid, 0);
        check("chain_busy", busy, 1);
        tick();
        check("chain_start", core_start, 1);
      end
      tick();
      for (int i = 0; i < S; i++) begin
        check("chain_b", core_b, (k == 1) ? W'(9 + i) : W'('h1000 * (k - 1) + i));
        b_fetch = 1'b1;
        tick();
      end
      b_fetch = 1'b0;
      push_words(W'('h1000 * k), S);
      finish_job();
    end
    check("chain_drain", res_valid, 1);
    drain(W'('h3000), S);

    // Short result count, then backpressure
    send_cmd(8'd1);
    tick();
    push_words(W'('h200), S - 1);
    finish_job();
    check("err_short", err, 1);
    check("drain_after_short", res_valid, 1);
    for (int i = 0; i < 20; i++) begin
      check("stall_data", res_data, W'('h200));
      tick();
    end
    check("stall_valid", res_valid, 1);
    drain(W'('h200), S - 1);

    // Load/command collision: load wins
    ld_valid = 1'b1; ld_sel = 2'd3; ld_data = '0; cmd_valid = 1'b1; cmd_iter = 8'd1;
    #1;
    check("collision_cmd_ready", cmd_ready, 0);
    tick();
    ld_valid = 1'b0; cmd_valid = 1'b0;
    check("collision_busy", busy, 0);
    send_cmd(8'd1);

`ifdef FIOS_MM_SEQUENCER_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) tick();
    check("wd_still_busy", busy, 1);
    tick();
    check("wd_idle", busy, 0);
    check("wd_err", err, 1);
    check("wd_no_drain", res_valid, 0);
    send_cmd(8'd1);
`else
    for (int i = 0; i < 150; i++) tick();
    check("no_wd_busy", busy, 1);
    check("no_wd_valid", res_valid, 0);
`endif

    // Reset mid-RUN
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_start", core_start, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_ld_ready", ld_ready, 1);
    check("midrst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();

    // Overflow push; cmd_iter=0 behaves as a single iteration
    send_cmd(8'd0);
    tick();
    push_words(W'('h400), S);
    check("err_before_extra", err, 0);
    push_words(W'('h7FF), 1);
    check("err_extra_push", err, 1);
    finish_job();
    check("overflow_drain", res_valid, 1);
    drain(W'('h400), S);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fios_mm_sequencer.md
Name: fios_mm_sequencer

Overview:
- Job-level front end for the FIOS Montgomery multiplier top.
- Buffers the A, B and P operands, each s words of WORD_WIDTH bits, loaded over a word-serial handshake.
- Drives the core's start, a, b and p inputs and services its a_shift, b_fetch and p_fetch strobes.
- Captures RES words and drains them over a valid/ready port.
- New over the previous generation: chained multiplies (RES fed back as B for N iterations), back-to-back jobs without host re-sequencing, and result-count checking.

Parameters:
- WORD_WIDTH, 17, width of one operand/result word.
- s, 8, words per operand.
- PE_NB, 8, PEs in the attached core; core_a_o carries PE_NB words.
- ITER_W, 8, width of the chained-iteration count.
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only).

Ports:
- clock_i, in, 1, clock.
- reset_i, in, 1, reset, synchronous active-high.
- ld_valid_i / ld_ready_o, in/out, 1, operand-word load handshake.
- ld_sel_i, in, 2, target buffer: 0=A, 1=B, 2=P, 3=invalid.
- ld_data_i, in, WORD_WIDTH, operand word, least significant first.
- cmd_valid_i / cmd_ready_o, in/out, 1, job-start handshake.
- cmd_iter_i, in, ITER_W, number of chained multiplies.
- res_valid_o / res_ready_i, out/in, 1, result drain handshake.
- res_data_o, out, WORD_WIDTH, result word, least significant first.
- busy_o, out, 1, FSM not IDLE.
- err_o, out, 1, sticky error flag.
- core_start_o, out, 1, one-cycle start pulse to the core.
- core_a_o, out, PE_NB*WORD_WIDTH, current A window.
- core_b_o / core_p_o, out, WORD_WIDTH, current B/P word.
- core_a_shift_i / core_b_fetch_i / core_p_fetch_i, in, 1, core strobes.
- core_res_push_i / core_done_i, in, 1, core result strobes.
- core_res_i, in, WORD_WIDTH, core result word.

Behaviour:
- Clock and reset: one clock, clock_i. reset_i is synchronous and active-high. Reset mid-operation aborts the job and returns to IDLE.
- Reset values: state IDLE, all pointers 0, iteration counter 0, core_start_o=0, res_valid_o=0, busy_o=0, err_o=0. ld_ready_o=1 and cmd_ready_o=1 in the cycle after reset. Buffer contents are not reset.
- FSM states: IDLE, START, RUN, CHAIN, DRAIN.
- IDLE:
  - ld_ready_o=1. An accepted word is written to buf[ld_sel_i][ptr]; that buffer's write pointer then wraps s-1 -> 0.
  - ld_sel_i=3: word is accepted and discarded.
  - cmd accepted (cmd_valid_i & cmd_ready_o): latch iter = max(cmd_iter_i,1), clear write pointers, go to START.
  - ld and cmd in the same cycle: the load wins and cmd_ready_o is 0 that cycle.
- START, one cycle:
  - A shift register reloaded from the A buffer, zero-padded to ceil(s/PE_NB)*PE_NB words.
  - B/P read pointers and res_ptr cleared.
  - core_start_o=1, registered, so it pulses exactly 1 cycle after cmd acceptance. Go to RUN.
- RUN:
  - core_a_shift_i: shift the A register down by PE_NB words, zero-filling the top.
  - core_b_o = Bbuf[b_ptr]. core_b_fetch_i advances b_ptr, wrapping s-1 -> 0. P behaves identically.
  - core_res_push_i: res_buf[res_ptr] <= core_res_i, res_ptr++. A push beyond s words is dropped and sets err_o.
  - core_done_i: if res_ptr != s, set err_o. Then decrement iter; if iter > 1 go to CHAIN, else go to DRAIN.
  - Push and done in the same cycle: the push is counted first.
- CHAIN, one cycle: Bbuf <= res_buf (whole array), then START. Done-to-next-start latency is 2 cycles.
- DRAIN:
  - res_valid_o=1, res_data_o=res_buf[rd_ptr].
  - rd_ptr++ on res_valid_o & res_ready_i. After the s-th word, go to IDLE.
  - res_ready_i held low stalls indefinitely with data stable.
- Core strobes outside RUN are ignored. err_o clears only on reset.
- busy_o=1 in every state except IDLE.

Optional Feature:
- Macro: FIOS_MM_SEQUENCER_TIMEOUT_EN.
- Defined: a watchdog counts cycles in RUN and is cleared at START. On reaching TIMEOUT_CYCLES it sets err_o and goes to IDLE without draining.
- Undefined: no counter; RUN waits for core_done_i indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- Package fios_seq_pkg holds:
  - state enum (IDLE, START, RUN, CHAIN, DRAIN);
  - buffer-select constants SEL_A=0, SEL_B=1, SEL_P=2;
  - function a_words(s, PE_NB) returning the padded A length.
- Sub-module fios_word_buf: s-word register file with a wrapping write pointer, a wrapping fetch pointer, and a parallel load/read port for CHAIN. Instantiated for B and P.

Test Plan:
- Single job: s=8, PE_NB=8, load A=1..8, B=9..16, P=17..24, cmd_iter=1, behavioural core pushing 8 words then done -> core_start_o 1 cycle after cmd, 8 drained words match the model, busy_o low after the last handshake.
- Fetch wrap: 16 b_fetch strobes -> core_b_o sequence 9..16, 9..16.
- Chain: cmd_iter=3 -> three core_start_o pulses each 2 cycles after the previous done; B for iterations 2 and 3 equals the prior RES; only the final RES is drained.
- Error: core issues 7 pushes then done -> err_o=1, DRAIN still entered. A 9th push also sets err_o.
- Backpressure/reset: res_ready_i low for 20 cycles holds word 0 stable; reset_i asserted mid-RUN -> IDLE next cycle, all outputs at reset values.
- Timeout (macro defined, TIMEOUT_CYCLES=100): core never signals done -> err_o set and IDLE entered 100 cycles after START; macro undefined -> stays in RUN.
